// File: rtl/cam_alloc_ctrl_32.sv
// cam_alloc_ctrl_32: allocation/invalidate/flush controller for a 32-entry CAM.
// Tracks entry occupancy, hands out the lowest free index and drives one-hot
// row strobes for writes (clr_o=0) and for a sequential 32-cycle flush (clr_o=1).
// Optional feature: define CAM_ALLOC_ERR_EN to add the sticky err_o output,
// which flags a write request made while the array is full.
module cam_alloc_ctrl_32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_req_i,
  output logic        wr_ready_o,
  output logic [4:0]  wr_idx_o,
  output logic [31:0] wr_en_o,
  output logic        clr_o,
  input  logic        inv_req_i,
  input  logic [4:0]  inv_idx_i,
  input  logic        flush_i,
  output logic [31:0] valid_o,
  output logic [5:0]  count_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        busy_o
`ifdef CAM_ALLOC_ERR_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

  state_t      state, state_next;
  logic [31:0] valid_next;
  logic [31:0] wr_en_next;
  logic        clr_next;
  logic [4:0]  fcnt, fcnt_next;
  logic [5:0]  count_next;
  logic [31:0] inv_mask;
  logic        accept;
  logic        found;
`ifdef CAM_ALLOC_ERR_EN
  logic        err_next;
`endif

  assign full_o     = (count_o == 6'd32);
  assign empty_o    = (count_o == 6'd0);
  assign busy_o     = (state != IDLE);
  assign wr_ready_o = (state == IDLE) && !full_o && !flush_i;
  assign accept     = wr_req_i && wr_ready_o;
  assign inv_mask   = inv_req_i ? (32'b1 << inv_idx_i) : '0;

  // Priority encoder: lowest-numbered free entry, 0 when every entry is taken.
  always_comb begin
    wr_idx_o = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!found && !valid_o[i]) begin
        wr_idx_o = i[4:0];
        found    = 1'b1;
      end
    end
  end

  // Next-state, next occupancy and next strobe decisions.
  always_comb begin
    state_next = state;
    valid_next = valid_o;
    wr_en_next = '0;
    clr_next   = 1'b0;
    fcnt_next  = fcnt;
`ifdef CAM_ALLOC_ERR_EN
    err_next   = err_o;
`endif
    case (state)
      IDLE: begin
        valid_next = valid_o & ~inv_mask;
        if (flush_i) begin
          // Entry edge already strobes and clears index 0.
          state_next    = FLUSH;
          fcnt_next     = '0;
          wr_en_next    = 32'h1;
          clr_next      = 1'b1;
          valid_next[0] = 1'b0;
        end else if (accept) begin
          // Invalidate applied first so a same-edge allocation always sticks.
          state_next           = WRITE;
          valid_next[wr_idx_o] = 1'b1;
          wr_en_next           = 32'b1 << wr_idx_o;
        end
`ifdef CAM_ALLOC_ERR_EN
        if (wr_req_i && full_o) err_next = 1'b1;
`endif
      end
      WRITE: begin
        valid_next = valid_o & ~inv_mask;
        state_next = IDLE;
      end
      FLUSH: begin
        if (fcnt == 5'd31) begin
          state_next = IDLE;
          fcnt_next  = '0;
`ifdef CAM_ALLOC_ERR_EN
          err_next   = 1'b0;
`endif
        end else begin
          fcnt_next             = fcnt + 5'd1;
          wr_en_next            = 32'b1 << fcnt_next;
          clr_next              = 1'b1;
          valid_next[fcnt_next] = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    count_next = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      count_next = count_next + 6'(valid_next[i]);
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Occupancy, strobe and flush-counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= '0;
      count_o <= '0;
      wr_en_o <= '0;
      clr_o   <= 1'b0;
      fcnt    <= '0;
    end else begin
      valid_o <= valid_next;
      count_o <= count_next;
      wr_en_o <= wr_en_next;
      clr_o   <= clr_next;
      fcnt    <= fcnt_next;
    end
  end

`ifdef CAM_ALLOC_ERR_EN
  // Sticky overflow-attempt flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_o <= 1'b0;
    else       err_o <= err_next;
  end
`endif

endmodule

// File: tb/tb_cam_alloc_ctrl_32.sv
// tb_cam_alloc_ctrl_32: directed scenarios plus random traffic, all checked
// against a queue-of-pending-strobes reference model of the allocator.
module tb_cam_alloc_ctrl_32;

  logic        clk_i = 1'b0;
  logic        rst_i, wr_req_i, wr_ready_o, clr_o, inv_req_i, flush_i;
  logic        full_o, empty_o, busy_o;
  logic [4:0]  wr_idx_o, inv_idx_i;
  logic [31:0] wr_en_o, valid_o;
  logic [5:0]  count_o;
`ifdef CAM_ALLOC_ERR_EN
  logic        err_o;
`endif

  always #5 clk_i = ~clk_i;

  cam_alloc_ctrl_32 dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_req_i   (wr_req_i),
    .wr_ready_o (wr_ready_o),
    .wr_idx_o   (wr_idx_o),
    .wr_en_o    (wr_en_o),
    .clr_o      (clr_o),
    .inv_req_i  (inv_req_i),
    .inv_idx_i  (inv_idx_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .busy_o     (busy_o)
`ifdef CAM_ALLOC_ERR_EN
    ,
    .err_o      (err_o)
`endif
  );

  // Reference model: occupancy bitmap plus a queue of strobes still to be shown.
  typedef struct {
    int unsigned idx;
    bit          clr;
  } strobe_t;

  strobe_t     sq[$];
  logic [31:0] mvalid;
  bit          merr;
  int          errors = 0;
  int          checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_count();
    int unsigned n = 0;
    for (int unsigned i = 0; i < 32; i++) n += 32'(mvalid[i]);
    return n;
  endfunction

  function automatic int unsigned m_free();
    for (int unsigned i = 0; i < 32; i++) if (!mvalid[i]) return i;
    return 0;
  endfunction

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model across the rising edge.
  task automatic step(input bit r, input bit w, input bit iv, input logic [4:0] ii, input bit f);
    bit          idle, in_write, full, acc, fl, inv_eff, was_last;
    logic [31:0] exp_en;
    bit          exp_clr;
    int unsigned widx, cnt;
    rst_i = r; wr_req_i = w; inv_req_i = iv; inv_idx_i = ii; flush_i = f;
    #1;
    idle     = (sq.size() == 0);
    in_write = !idle && !sq[0].clr;
    cnt      = m_count();
    full     = (cnt == 32);
    exp_en   = idle ? 32'h0 : (32'h1 << sq[0].idx);
    exp_clr  = !idle && sq[0].clr;
    widx     = m_free();
    check_val("wr_en",  wr_en_o, exp_en);
    check_val("clr",    32'(clr_o), 32'(exp_clr));
    check_val("valid",  valid_o, mvalid);
    check_val("count",  32'(count_o), cnt);
    check_val("full",   32'(full_o), 32'(full));
    check_val("empty",  32'(empty_o), 32'(cnt == 0));
    check_val("busy",   32'(busy_o), 32'(!idle));
    check_val("ready",  32'(wr_ready_o), 32'(idle && !full && !f));
    check_val("wr_idx", 32'(wr_idx_o), widx);
`ifdef CAM_ALLOC_ERR_EN
    check_val("err",    32'(err_o), 32'(merr));
`endif
    acc     = w && idle && !full && !f;
    fl      = idle && f;
    inv_eff = iv && (idle || in_write);
    @(posedge clk_i);
    if (r) begin
      sq.delete();
      mvalid = '0;
      merr   = 1'b0;
    end else begin
      if (w && idle && full) merr = 1'b1;
      if (!idle) begin
        was_last = sq[0].clr && (sq[0].idx == 31);
        void'(sq.pop_front());
        if (was_last) merr = 1'b0;
      end
      if (inv_eff) mvalid[ii] = 1'b0;
      if (fl) begin
        for (int unsigned k = 0; k < 32; k++) sq.push_back('{k, 1'b1});
      end else if (acc) begin
        mvalid[widx] = 1'b1;
        sq.push_back('{widx, 1'b0});
      end
      if (sq.size() > 0 && sq[0].clr) mvalid[sq[0].idx] = 1'b0;
    end
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] onehot;
    rst_i = 1'b1; wr_req_i = 1'b0; inv_req_i = 1'b0; inv_idx_i = '0; flush_i = 1'b0;
    mvalid = '0; merr = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);

    // Reset state.
    check_val("rst_count", 32'(count_o), 32'd0);
    check_val("rst_empty", 32'(empty_o), 32'd1);
    step(0, 0, 0, 0, 0);

    // Three back-to-back writes.
    step(0, 1, 0, 0, 0); check_val("b2b_en0", wr_en_o, 32'h1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); check_val("b2b_en1", wr_en_o, 32'h2);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); check_val("b2b_en2", wr_en_o, 32'h4);
    step(0, 0, 0, 0, 0);
    check_val("b2b_valid", valid_o, 32'h7);
    check_val("b2b_count", 32'(count_o), 32'd3);

    // Fill, then free entry 13 and reallocate it.
    step(1, 0, 0, 0, 0);
    repeat (64) step(0, 1, 0, 0, 0);
    check_val("fill_full", 32'(full_o), 32'd1);
    step(0, 0, 1, 5'd13, 0);
    check_val("inv13_full", 32'(full_o), 32'd0);
    check_val("inv13_idx", 32'(wr_idx_o), 32'd13);
    step(0, 1, 0, 0, 0);
    check_val("realloc_en", wr_en_o, 32'h2000);

    // Write requests while full are refused.
    repeat (4) step(0, 1, 0, 0, 0);
    check_val("full_no_strobe", wr_en_o, 32'h0);
    check_val("full_ready", 32'(wr_ready_o), 32'd0);
`ifdef CAM_ALLOC_ERR_EN
    check_val("full_err", 32'(err_o), 32'd1);
`endif

    // Flush beats a simultaneous write request.
    step(0, 1, 0, 0, 1);
    for (int unsigned k = 0; k < 32; k++) begin
      onehot = 32'h1 << k;
      check_val("flush_en", wr_en_o, onehot);
      check_val("flush_clr", 32'(clr_o), 32'd1);
      step(0, 0, 0, 0, 0);
    end
    check_val("flush_valid", valid_o, 32'h0);
    check_val("flush_empty", 32'(empty_o), 32'd1);
    check_val("flush_busy", 32'(busy_o), 32'd0);

    // Reset in the middle of a flush.
    repeat (6) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (10) step(0, 0, 0, 0, 0);
    check_val("mid_flush_en", wr_en_o, 32'h400);
    step(1, 0, 0, 0, 0);
    check_val("abort_busy", 32'(busy_o), 32'd0);
    check_val("abort_en", wr_en_o, 32'h0);
    check_val("abort_valid", valid_o, 32'h0);
    repeat (3) step(0, 0, 0, 0, 0);

    // Same-edge invalidate of entry 0 and allocation of entry 2.
    repeat (4) step(0, 1, 0, 0, 0);
    check_val("pre_inv_valid", valid_o, 32'h3);
    step(0, 1, 1, 5'd0, 0);
    check_val("inv_acc_valid", valid_o, 32'h6);
    check_val("inv_acc_count", 32'(count_o), 32'd2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(127) == 0, $urandom_range(9) < 7, $urandom_range(9) < 2,
           5'($urandom_range(31)), $urandom_range(79) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_alloc_ctrl_32.md
CAM_ALLOC_CTRL_32 -- requirements
Module: cam_alloc_ctrl_32

Interface
REQ-001 The block SHALL have no parameters; depth is fixed at 32 entries with a 5-bit index.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 wr_req_i  input  1  request to allocate and write one CAM entry.
REQ-005 wr_ready_o  output  1  allocation accepted this cycle when high together with wr_req_i.
REQ-006 wr_idx_o  output  5  lowest-numbered free entry, combinational from valid_o.
REQ-007 wr_en_o  output  32  registered one-hot write/clear strobe to the CAM array row drivers.
REQ-008 clr_o  output  1  high when wr_en_o is a clear (flush) strobe rather than a write.
REQ-009 inv_req_i  input  1  invalidate request for entry inv_idx_i.
REQ-010 inv_idx_i  input  5  entry to invalidate.
REQ-011 flush_i  input  1  request to clear all 32 entries.
REQ-012 valid_o  output  32  occupancy bitmap, bit n set means entry n is allocated.
REQ-013 count_o  output  6  number of set bits in valid_o, range 0..32.
REQ-014 full_o / empty_o  output  1 each  count_o==32 / count_o==0.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, WRITE and FLUSH.
REQ-017 wr_ready_o SHALL equal (state==IDLE) AND NOT full_o AND NOT flush_i.
REQ-018 On an accept edge (wr_req_i AND wr_ready_o), the block SHALL set valid_o[wr_idx_o] and latch one-hot(wr_idx_o) into wr_en_o.
REQ-019 After an accept edge, the block SHALL enter WRITE: wr_en_o is one-hot for exactly one cycle with clr_o=0, then the FSM returns to IDLE.
REQ-020 Throughput SHALL be at most one write per 2 cycles.
REQ-021 In IDLE with flush_i=1, the block SHALL enter FLUSH and take priority over wr_req_i.
REQ-022 In FLUSH, a 5-bit counter SHALL walk 0..31, one index per cycle, with wr_en_o=one-hot(counter), clr_o=1, and valid_o[counter] cleared on the same edge.
REQ-023 After index 31 is strobed, FLUSH SHALL return to IDLE; a flush is exactly 32 cycles of strobes.
REQ-024 flush_i SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-025 inv_req_i SHALL clear valid_o[inv_idx_i] on the next edge in IDLE or WRITE, with no strobe on wr_en_o.
REQ-026 inv_req_i SHALL be ignored in FLUSH.
REQ-027 Invalidating an entry that is already free SHALL be a no-op.
REQ-028 If an invalidate and an accept occur on the same edge, both SHALL take effect, and count_o SHALL change by 0.
REQ-029 When full_o is high, wr_ready_o SHALL stay low and wr_idx_o SHALL be 5'd0.
REQ-030 count_o SHALL be registered and consistent with valid_o every cycle.
REQ-031 wr_en_o SHALL be all-zero in IDLE and SHALL never have more than one bit set.

Reset
REQ-032 While rst_i is high at an edge, the block SHALL set: state IDLE, valid_o=0, wr_en_o=0, clr_o=0, count_o=0, flush counter=0, busy_o=0.
REQ-033 Reset asserted during WRITE or FLUSH SHALL abandon the operation with no further strobes.
REQ-034 All inputs SHALL be ignored during the reset cycle.

Configuration
REQ-035 With macro CAM_ALLOC_ERR_EN defined, the block SHALL add port err_o (output, 1 bit).
REQ-036 With CAM_ALLOC_ERR_EN defined, err_o SHALL be set sticky when wr_req_i=1 in IDLE while full_o=1, and SHALL be cleared only by reset or by completion of a FLUSH.
REQ-037 Without CAM_ALLOC_ERR_EN, the err_o port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then 3 back-to-back write requests -> wr_en_o=0x1, 0x2, 0x4 on alternate cycles; count_o=3; valid_o=0x7.
REQ-039 Fill all 32 entries, then invalidate 13 -> full_o drops, wr_idx_o=13; next write strobes wr_en_o=0x2000.
REQ-040 Full array with wr_req_i held high -> wr_ready_o=0 and no wr_en_o strobe; with CAM_ALLOC_ERR_EN, err_o=1 until a flush completes.
REQ-041 flush_i and wr_req_i high together in IDLE -> FLUSH wins; 32 clr_o strobes 0x1..0x80000000; valid_o=0, empty_o=1, busy_o low afterwards.
REQ-042 rst_i asserted at flush index 10 -> next cycle state IDLE, wr_en_o=0, valid_o=0, no further strobes.
REQ-043 Invalidate entry 0 on the same edge as accepting a write to entry 2 (valid_o=0x3) -> valid_o=0x6, count_o unchanged at 2.
